// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, reset PC, NOP encoding and the fetch-queue entry type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with flush, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner and fetch issuer; buffers {pc, instr} pairs for decode.
// Credits (count + inflight) keep a returning word from ever meeting a full queue.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0]   r_pc;
  logic [31:0]   r_addr_q;
  logic          r_inflight;
  logic          r_en;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_kill;
  logic [31:0]   w_redirect_pc;
  fetch_entry_t  w_wentry;
  fetch_entry_t  w_head;
  assign w_kill          = i_redirect_valid;
  assign w_redirect_pc   = i_redirect_pc & ~32'h3;
  assign o_imem_req      = r_en && !w_kill && !w_full && (w_count + CW'(r_inflight) < CW'(DEPTH));
  assign o_imem_addr     = r_pc;
  assign w_push          = r_inflight && !w_kill;
  assign w_pop           = o_id_valid && i_id_ready;
  assign w_wentry.pc     = r_addr_q;
  assign w_wentry.instr  = i_imem_rdata;
  assign o_id_valid      = !w_empty;
  assign o_id_pc         = o_id_valid ? w_head.pc : '0;
  assign o_id_instr      = o_id_valid ? w_head.instr : '0;
  // r_en holds off the first request until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc       <= RESET_PC;
      r_addr_q   <= '0;
      r_inflight <= 1'b0;
      r_en       <= 1'b0;
    end else begin
      r_en       <= 1'b1;
      r_inflight <= o_imem_req;
      if (w_kill) begin
        r_pc <= w_redirect_pc;
      end else if (o_imem_req) begin
        r_pc     <= r_pc + 32'd4;
        r_addr_q <= r_pc;
      end
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_kill),
    .i_wdata  (w_wentry),
    .o_rdata  (w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench; stimulus queues expected entries, monitors compare handshakes.
module tb_if_fetch_queue;
  import riscv_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0;
  logic [31:0] addr0;
  logic [31:0] rdata0 = '0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        valid0;
  logic        ready0 = 1'b1;
  logic [31:0] pc0;
  logic [31:0] instr0;
  logic        rst1_n = 1'b0;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] rdata1 = '0;
  logic        valid1;
  logic [31:0] pc1;
  logic [31:0] instr1;
  int checks = 0;
  int failures = 0;
  int idx1 = 0;
  fetch_entry_t sb[$];
  logic [31:0] exp1_pc [3];
  logic [31:0] exp1_in [3];

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .o_imem_req(req0), .o_imem_addr(addr0), .i_imem_rdata(rdata0),
    .i_redirect_valid(rv), .i_redirect_pc(rpc), .o_id_valid(valid0), .i_id_ready(ready0),
    .o_id_pc(pc0), .o_id_instr(instr0));

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .i_clk(clk), .i_reset_n(rst1_n), .o_imem_req(req1), .o_imem_addr(addr1), .i_imem_rdata(rdata1),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0), .o_id_valid(valid1), .i_id_ready(1'b1),
    .o_id_pc(pc1), .o_id_instr(instr1));

  // instruction memory: word at address A is A>>2, one cycle after the request
  always @(posedge clk) begin
    if (req0) rdata0 <= addr0 >> 2;
    if (req1) rdata1 <= addr1 >> 2;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{pc: base + 32'(4 * i), instr: (base + 32'(4 * i)) >> 2});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    int got = 0;
    ready0 = 1'b1;
    for (int c = 0; c < 60 && got < n; c++) begin
      @(negedge clk);
      if (valid0) got++;
    end
    chk("drain_done", 32'(got), 32'(n));
    @(posedge clk);
    #1 ready0 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (valid0 && ready0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop got_pc=%h exp=none", pc0);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        chk("id_pc", pc0, e.pc);
        chk("id_instr", instr0, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (valid1 && idx1 < 3) begin
      chk("wrap_pc", pc1, exp1_pc[idx1]);
      chk("wrap_instr", instr1, exp1_in[idx1]);
      idx1++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_req;
    int t_val;
    int nreq;
    logic [31:0] first_addr;
    exp1_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp1_in = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    chk("rst_req", {31'b0, req0}, 32'd0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_instr", instr0, 32'h0);
    // streaming from reset with decode always ready
    push_seq(32'h0, 12);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    t_req = -1;
    t_val = -1;
    for (int c = 0; c < 20 && t_val < 0; c++) begin
      @(negedge clk);
      if (req0 && t_req < 0) t_req = c;
      if (valid0) t_val = c;
    end
    chk("first_latency", 32'(t_val - t_req), 32'd2);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      chk("no_bubble", {31'b0, valid0}, 32'd1);
    end
    @(posedge clk);
    #1 ready0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid0}, 32'd0);
    chk("async_rst_req", {31'b0, req0}, 32'd0);
    chk("async_rst_pc", pc0, 32'h0);
    chk("sb_after_a", 32'(sb.size()), 32'd0);
    // stall from reset: only DEPTH requests may go out
    @(posedge clk);
    #1;
    do_reset();
    nreq = 0;
    first_addr = 32'hFFFF_FFFF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0) begin
        if (nreq == 0) first_addr = addr0;
        nreq++;
      end
    end
    chk("stall_nreq", 32'(nreq), 32'd4);
    chk("restart_addr", first_addr, 32'h0);
    chk("stall_req_low", {31'b0, req0}, 32'd0);
    chk("stall_valid", {31'b0, valid0}, 32'd1);
    chk("stall_head_pc", pc0, 32'h0);
    @(posedge clk);
    #1;
    push_seq(32'h0, 10);
    drain(10);
    // redirect with 3 queued and 1 inflight
    do_reset();
    t_req = -1;
    for (int c = 0; c < 10 && t_req < 0; c++) begin
      @(negedge clk);
      if (req0) t_req = c;
    end
    chk("c_first_req", {31'b0, req0}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    rv = 1'b1;
    rpc = 32'h100;
    @(negedge clk);
    chk("redir_req_low", {31'b0, req0}, 32'd0);
    chk("redir_cycle_valid", {31'b0, valid0}, 32'd1);
    @(posedge clk);
    #1 rv = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'b0, valid0}, 32'd0);
    chk("redir_addr", addr0, 32'h100);
    chk("redir_req", {31'b0, req0}, 32'd1);
    @(posedge clk);
    #1;
    push_seq(32'h100, 4);
    drain(4);
    // misaligned target, then back-to-back redirects
    rv = 1'b1;
    rpc = 32'h203;
    @(posedge clk);
    #1 rv = 1'b0;
    @(negedge clk);
    chk("align_addr", addr0, 32'h200);
    @(posedge clk);
    #1;
    rv = 1'b1;
    rpc = 32'h40;
    @(posedge clk);
    #1 rpc = 32'h80;
    @(negedge clk);
    chk("b2b_req_low", {31'b0, req0}, 32'd0);
    @(posedge clk);
    #1 rv = 1'b0;
    @(negedge clk);
    chk("b2b_addr", addr0, 32'h80);
    chk("b2b_valid", {31'b0, valid0}, 32'd0);
    @(posedge clk);
    #1;
    push_seq(32'h80, 2);
    drain(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("wrap_count", 32'(idx1), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
